// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: fetches a 16-bit word at pc, issues its fields
// downstream with valid/ready backpressure, and resolves jumps on acceptance.
module fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [3:0]  instr_opcode,
  output logic [1:0]  instr_rd,
  output logic [1:0]  instr_rs,
  output logic [7:0]  instr_imm,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        jump_zero,
  input  logic        zero_flag,
  output logic [7:0]  pc,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  // Handshakes: imem_req/imem_valid and instr_valid/instr_ready each complete
  // on a rising edge where both are high; the requester holds its request and
  // payload unchanged until that edge.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    branch_taken = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // The halt decision uses the word being latched so HALT is entered
        // on the same edge, leaving pc at the halt instruction's address.
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = (imem_data[15:12] == HALT_OPCODE) ? S_HALT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          branch_taken = jump | (jump_zero & zero_flag);
          pc_d         = branch_taken ? ir_q[7:0] : pc_q + 8'd1;
          state_d      = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req     = (state_q == S_FETCH);
  assign instr_valid  = (state_q == S_ISSUE);
  assign halted       = (state_q == S_HALT);
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr_opcode = ir_q[15:12];
  assign instr_rd     = ir_q[11:10];
  assign instr_rs     = ir_q[9:8];
  assign instr_imm    = ir_q[7:0];
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed program plus randomized fetch/issue traffic
// checked against a memory-array and program-counter reference model.
module tb_fetch_unit;

  localparam logic [7:0] RESET_PC    = 8'h00;
  localparam logic [3:0] HALT_OPCODE = 4'hF;

  // clock / reset
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [3:0]  instr_opcode;
  logic [1:0]  instr_rd;
  logic [1:0]  instr_rs;
  logic [7:0]  instr_imm;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic        jump_zero;
  logic        zero_flag;
  logic [7:0]  pc;
  logic        halted;
  logic [1:0]  dbg_state;

  fetch_unit #(.RESET_PC(RESET_PC), .HALT_OPCODE(HALT_OPCODE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .imem_valid   (imem_valid),
    .instr_opcode (instr_opcode),
    .instr_rd     (instr_rd),
    .instr_rs     (instr_rs),
    .instr_imm    (instr_imm),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .jump         (jump),
    .jump_zero    (jump_zero),
    .zero_flag    (zero_flag),
    .pc           (pc),
    .halted       (halted),
    .dbg_state    (dbg_state)
  );

  // reference model and scoreboard
  logic [15:0] mem [256];
  logic [7:0]  model_pc;
  logic [15:0] exp_q [$];
  int          n_checks;
  int          n_errors;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fields();
    return {instr_opcode, instr_rd, instr_rs, instr_imm};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pc"}, {8'h00, pc}, {8'h00, RESET_PC});
    check_eq({tag, "_req"}, {15'h0, imem_req}, 16'h0);
    check_eq({tag, "_ivalid"}, {15'h0, instr_valid}, 16'h0);
    check_eq({tag, "_halted"}, {15'h0, halted}, 16'h0);
    check_eq({tag, "_fields"}, fields(), 16'h0000);
  endtask

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    model_pc = RESET_PC;
  endtask

  task automatic fetch_issue(input int wait_n, input int stall_n,
                             input logic j, input logic jz, input logic zf,
                             input logic noise, input logic rst_mid,
                             output logic hit_halt);
    logic [15:0] word;
    int          n;
    hit_halt = 1'b0;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("fetch_req", {15'h0, imem_req}, 16'h1);
    check_eq("fetch_addr", {8'h00, imem_addr}, {8'h00, model_pc});
    for (int w = 0; w < wait_n; w++) begin
      imem_valid = 1'b0;
      imem_data  = 16'($urandom);
      if (noise) start = 1'($urandom);
      @(negedge clk);
      start = 1'b0;
      check_eq("wait_req", {15'h0, imem_req}, 16'h1);
      check_eq("wait_ivalid", {15'h0, instr_valid}, 16'h0);
    end
    word       = mem[model_pc];
    imem_data  = word;
    imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = 16'($urandom);
    if (word[15:12] == HALT_OPCODE) begin
      hit_halt = 1'b1;
      check_eq("halt_flag", {15'h0, halted}, 16'h1);
      check_eq("halt_ivalid", {15'h0, instr_valid}, 16'h0);
      check_eq("halt_req", {15'h0, imem_req}, 16'h0);
      check_eq("halt_pc", {8'h00, pc}, {8'h00, model_pc});
      return;
    end
    exp_q.push_back(word);
    check_eq("issue_valid", {15'h0, instr_valid}, 16'h1);
    check_eq("issue_req", {15'h0, imem_req}, 16'h0);
    check_eq("issue_fields", fields(), exp_q[0]);
    if (rst_mid) begin
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("rst_mid");
      @(negedge clk);
      rst_n    = 1'b1;
      model_pc = RESET_PC;
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check_eq("post_rst_req", {15'h0, imem_req}, 16'h0);
        check_eq("post_rst_pc", {8'h00, pc}, {8'h00, RESET_PC});
      end
      return;
    end
    for (int s = 0; s < stall_n; s++) begin
      instr_ready = 1'b0;
      jump        = 1'($urandom);
      jump_zero   = 1'($urandom);
      zero_flag   = 1'($urandom);
      if (noise) begin
        start      = 1'($urandom);
        imem_valid = 1'($urandom);
      end
      @(negedge clk);
      start      = 1'b0;
      imem_valid = 1'b0;
      check_eq("stall_valid", {15'h0, instr_valid}, 16'h1);
      check_eq("stall_fields", fields(), exp_q[0]);
      check_eq("stall_pc", {8'h00, pc}, {8'h00, model_pc});
    end
    instr_ready = 1'b1;
    jump        = j;
    jump_zero   = jz;
    zero_flag   = zf;
    @(negedge clk);
    instr_ready = 1'b0;
    jump        = 1'b0;
    jump_zero   = 1'b0;
    zero_flag   = 1'b0;
    void'(exp_q.pop_front());
    if (j || (jz && zf)) model_pc = word[7:0];
    else                 model_pc = model_pc + 8'd1;
    check_eq("accept_ivalid", {15'h0, instr_valid}, 16'h0);
    check_eq("accept_req", {15'h0, imem_req}, 16'h1);
    check_eq("accept_addr", {8'h00, imem_addr}, {8'h00, model_pc});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        hh;
    logic [15:0] word;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    imem_data   = 16'h0;
    imem_valid  = 1'b0;
    instr_ready = 1'b0;
    jump        = 1'b0;
    jump_zero   = 1'b0;
    zero_flag   = 1'b0;
    model_pc    = RESET_PC;
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h2040;
    mem[8'h40] = 16'h3040;
    mem[8'h41] = 16'h50FF;
    mem[8'hFF] = 16'h60AA;
    mem[8'h02] = 16'h7011;
    mem[8'h03] = 16'h8022;
    mem[8'h04] = 16'h9033;
    mem[8'h05] = 16'hF000;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_req", {15'h0, imem_req}, 16'h0);
    check_eq("idle_ivalid", {15'h0, instr_valid}, 16'h0);

    do_start();
    fetch_issue(2, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hh);  // 00 -> 01 after stall
    fetch_issue(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hh);  // jump -> 40
    fetch_issue(1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, hh);  // jz taken -> 40
    fetch_issue(0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, hh);  // jz not taken -> 41
    fetch_issue(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, hh);  // both -> FF
    fetch_issue(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hh);  // FF wraps -> 00
    for (int k = 0; k < 5; k++)
      fetch_issue(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hh);
    fetch_issue(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hh);  // F000 at 05
    check_eq("halt_seen", {15'h0, hh}, 16'h1);
    for (int k = 0; k < 3; k++) begin
      jump       = 1'b1;
      imem_valid = 1'b1;
      @(negedge clk);
      check_eq("halt_hold", {halted, imem_req, instr_valid, 5'h0, pc}, {3'b100, 5'h0, 8'h05});
    end
    jump       = 1'b0;
    imem_valid = 1'b0;
    do_start();
    fetch_issue(0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, hh);  // reset mid-ISSUE
    do_start();

    for (int i = 0; i < 150; i++) begin
      word = 16'($urandom);
      if (word[15:12] == HALT_OPCODE && $urandom_range(0, 3) != 0) word[15:12] = 4'h0;
      mem[model_pc] = word;
      fetch_issue($urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, hh);
      if (hh) begin
        @(negedge clk);
        check_eq("rnd_halt_hold", {15'h0, halted}, 16'h1);
        do_start();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the PC loaded at reset and on every start.
REQ-002 SHALL have parameter HALT_OPCODE, default 4'hF, meaning the opcode that stops fetching.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; reset asserts immediately, independent of clk.
REQ-004 SHALL have port clk  input  1  system clock, all state on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  begin fetching from RESET_PC (IDLE/HALT only).
REQ-007 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-008 SHALL have port imem_addr  output  8  instruction address, always equal to pc.
REQ-009 SHALL have port imem_data  input  16  instruction word: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm/target.
REQ-010 SHALL have port imem_valid  input  1  imem_data valid this cycle.
REQ-011 SHALL have port instr_opcode  output  4  opcode to the decoder.
REQ-012 SHALL have ports instr_rd and instr_rs  output  2 each  register fields.
REQ-013 SHALL have port instr_imm  output  8  immediate or jump target.
REQ-014 SHALL have port instr_valid  output  1  issued instruction fields are valid.
REQ-015 SHALL have port instr_ready  input  1  downstream accepts the instruction; jump/jump_zero/zero_flag are valid this cycle.
REQ-016 SHALL have ports jump, jump_zero, zero_flag  input  1 each  decoder branch controls and ALU zero flag.
REQ-017 SHALL have port pc  output  8  current program counter.
REQ-018 SHALL have port halted  output  1  high while in HALT.

Function
REQ-019 SHALL implement states IDLE, FETCH, ISSUE and HALT.
REQ-020 SHALL, in IDLE, assert no outputs except pc; start=1 loads pc<=RESET_PC and moves to FETCH.
REQ-021 SHALL, in FETCH, hold imem_req=1 until imem_valid=1; on that edge it latches imem_data into a 16-bit instruction register.
REQ-022 SHALL move FETCH->HALT when the latched opcode equals HALT_OPCODE; otherwise it moves FETCH->ISSUE. pc is unchanged in both cases.
REQ-023 SHALL drive instr_* from the instruction register, with instr_valid=1 only in ISSUE and the fields stable while instr_valid=1.
REQ-024 SHALL assert instr_valid exactly 1 cycle after the imem_valid edge.
REQ-025 SHALL stay in ISSUE while instr_ready=0 (backpressure, any duration).
REQ-026 SHALL, on an ISSUE edge with instr_ready=1, set pc <= instr_imm if jump=1 or (jump_zero=1 and zero_flag=1), else pc <= pc+1, then move to FETCH.
REQ-027 SHALL wrap pc+1 modulo 256 (8'hFF -> 8'h00) with no flag.
REQ-028 SHALL treat jump and jump_zero both high as a taken jump to instr_imm.
REQ-029 SHALL ignore jump, jump_zero and zero_flag in every state except ISSUE with instr_ready=1.
REQ-030 SHALL ignore imem_valid outside FETCH, and ignore start outside IDLE/HALT.
REQ-031 SHALL, in HALT, set halted=1, imem_req=0, instr_valid=0 and hold pc at the halt instruction's address; start=1 loads RESET_PC and moves to FETCH.
REQ-032 SHALL keep imem_req and instr_valid never high in the same cycle.

Reset
REQ-033 SHALL, while rst_n=0, force state=IDLE, pc=RESET_PC, instruction register=16'h0000, imem_req=0, instr_valid=0 and halted=0.
REQ-034 SHALL abort a reset taken mid-FETCH or mid-ISSUE with no pc update; the first fetch after reset requires start.

Verification
REQ-035 SHALL cover: reset, start, memory returning 16'h1234 after a 2-cycle wait -> imem_addr=8'h00, then instr_valid=1 with opcode 4'h1, rd 2'b00, rs 2'b10, imm 8'h34, one cycle after imem_valid.
REQ-036 SHALL cover: ISSUE with instr_ready=0 for 3 cycles then 1 -> fields held constant, pc 8'h00->8'h01 only on the accepting edge.
REQ-037 SHALL cover: jump=1 with instr_imm=8'h40 -> next imem_addr=8'h40; jump_zero=1 with zero_flag=0 -> pc+1; jump_zero=1 with zero_flag=1 -> 8'h40.
REQ-038 SHALL cover: pc=8'hFF, non-branch instruction accepted -> next imem_addr=8'h00.
REQ-039 SHALL cover: instruction 16'hF000 at 8'h05 -> halted=1, pc=8'h05, no instr_valid; then start -> FETCH at 8'h00.
REQ-040 SHALL cover: rst_n pulsed low mid-ISSUE -> outputs reach reset values asynchronously, and there is no fetch until start.
